// File: rtl/freq_meas_sched.sv
// Round-robin measurement scheduler in front of a single shared frequency meter:
// picks a requesting channel, switches the input mux, lets it settle, starts the meter and collects the result.
module freq_meas_sched #(
  parameter int          N_CH    = 4,
  parameter int          SETTLE  = 8,
  parameter logic [27:0] TIMEOUT = 28'd600_000
) (
  input  logic            std_clk,
  input  logic            std_reset,
  input  logic [N_CH-1:0] req,
  output logic [1:0]      sel,
  output logic            meas_start,
  input  logic            meas_end,
  input  logic [9:0]      meas_val,
  output logic            meas_abort_n,
  output logic            done,
  output logic [9:0]      result,
  output logic [1:0]      result_ch,
  output logic            err,
  output logic            busy,
  output logic [N_CH-1:0] pending
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_START  = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       last_grant;
  logic [SET_W-1:0] settle_cnt;
  logic [27:0]      wait_cnt;
  logic             meas_end_d;
  logic [2:0]       pick;
  logic             grant;
  logic             finish_ok;
  logic             finish_to;
  logic [N_CH-1:0]  clr_mask;

  // Returns {found, index}: first pending channel at or after last+1, wrapping upward.
  function automatic logic [2:0] rr_pick(input logic [N_CH-1:0] pend, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (pend[idx] && !rr_pick[2]) rr_pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    pick      = rr_pick(pending, last_grant);
    case (state)
      ST_IDLE: begin
        if (pick[2]) begin
          grant     = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SET_W'(SETTLE - 1)) state_nxt = ST_START;
      end
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A completion edge on the last allowed cycle still counts as a good result.
        if (meas_end && !meas_end_d) begin
          finish_ok = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wait_cnt == TIMEOUT - 28'd1) begin
          finish_to = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    clr_mask = grant ? (N_CH'(1) << pick[1:0]) : '0;
  end

  assign meas_start = (state == ST_START);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge std_clk or negedge std_reset) begin
    if (!std_reset) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge std_clk or negedge std_reset) begin
    if (!std_reset) begin
      pending      <= '0;
      sel          <= 2'd0;
      last_grant   <= 2'd3;
      settle_cnt   <= '0;
      wait_cnt     <= '0;
      meas_end_d   <= 1'b0;
      done         <= 1'b0;
      meas_abort_n <= 1'b1;
      result       <= '0;
      result_ch    <= 2'd0;
      err          <= 1'b0;
    end else begin
      meas_end_d   <= meas_end;
      // A request arriving on the grant cycle re-arms the channel it clears.
      pending      <= (pending & ~clr_mask) | req;
      done         <= finish_ok | finish_to;
      meas_abort_n <= ~finish_to;
      settle_cnt   <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
      wait_cnt     <= (state == ST_WAIT) ? wait_cnt + 28'd1 : '0;
      if (grant) begin
        sel        <= pick[1:0];
        last_grant <= pick[1:0];
      end
      if (finish_ok) begin
        result    <= meas_val;
        result_ch <= sel;
        err       <= 1'b0;
      end else if (finish_to) begin
        result    <= '0;
        result_ch <= sel;
        err       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_meas_sched.sv
// Bench for freq_meas_sched: behavioural meter, cycle-timeline reference model and directed scenarios.
module tb_freq_meas_sched;

  localparam int          SETTLE  = 4;
  localparam logic [27:0] TIMEOUT = 28'd100;

  logic       std_clk   = 1'b0;
  logic       std_reset = 1'b1;
  logic [3:0] req       = 4'b0;
  logic [1:0] sel;
  logic       meas_start;
  logic       meas_end;
  logic [9:0] meas_val  = 10'd0;
  logic       meas_abort_n;
  logic       done;
  logic [9:0] result;
  logic [1:0] result_ch;
  logic       err;
  logic       busy;
  logic [3:0] pending;

  logic meter_end = 1'b0;
  logic spur_end  = 1'b0;
  int   meter_lat = 0;
  int   meter_cnt = 0;
  assign meas_end = meter_end | spur_end;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  freq_meas_sched #(.N_CH(4), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .std_clk(std_clk), .std_reset(std_reset), .req(req), .sel(sel),
    .meas_start(meas_start), .meas_end(meas_end), .meas_val(meas_val),
    .meas_abort_n(meas_abort_n), .done(done), .result(result),
    .result_ch(result_ch), .err(err), .busy(busy), .pending(pending)
  );

  always #5 std_clk = ~std_clk;

  // Meter: after seeing start, raises end (held) meter_lat cycles later; 0 means never.
  initial forever begin
    logic st, ab, rs;
    @(negedge std_clk);
    st = meas_start; ab = !meas_abort_n; rs = std_reset;
    #1;
    if (!rs || ab) begin
      meter_cnt = 0; meter_end = 1'b0;
    end else if (st) begin
      meter_end = 1'b0; meter_cnt = meter_lat;
    end else if (meter_cnt > 0) begin
      meter_cnt--;
      if (meter_cnt == 0) meter_end = 1'b1;
    end
  end

  // Reference model: a single elapsed-time counter per measurement, t cycles since the grant edge.
  bit         m_busy  = 1'b0;
  int         m_t     = 0;
  logic [1:0] m_sel   = 2'd0;
  logic [1:0] m_last  = 2'd3;
  logic [3:0] m_pend  = 4'd0;
  logic       m_done  = 1'b0;
  logic       m_abort = 1'b0;
  logic       m_err   = 1'b0;
  logic [9:0] m_res   = 10'd0;
  logic [1:0] m_rch   = 2'd0;
  logic       m_endp  = 1'b0;
  logic [3:0] m_np;
  int         m_base, m_c, m_w;

  initial forever begin
    @(posedge std_clk or negedge std_reset);
    if (!std_reset) begin
      m_busy = 1'b0; m_t = 0; m_sel = 2'd0; m_last = 2'd3; m_pend = 4'd0;
      m_done = 1'b0; m_abort = 1'b0; m_err = 1'b0; m_res = 10'd0; m_rch = 2'd0;
      m_endp = 1'b0;
    end else begin
      m_done = 1'b0; m_abort = 1'b0;
      m_np = m_pend;
      if (!m_busy) begin
        m_base = int'(m_last);
        for (int k = 1; k <= 4; k++) begin
          m_c = (m_base + k) % 4;
          if (!m_busy && m_pend[m_c]) begin
            m_busy = 1'b1; m_t = 0; m_sel = 2'(m_c); m_last = 2'(m_c); m_np[m_c] = 1'b0;
          end
        end
      end else if (m_t <= SETTLE) begin
        m_t++;
      end else begin
        m_w = m_t - SETTLE - 1;
        if (meas_end && !m_endp) begin
          m_done = 1'b1; m_err = 1'b0; m_res = meas_val; m_rch = m_sel; m_busy = 1'b0;
        end else if (m_w == int'(TIMEOUT) - 1) begin
          m_done = 1'b1; m_abort = 1'b1; m_err = 1'b1; m_res = 10'd0; m_rch = m_sel; m_busy = 1'b0;
        end else begin
          m_t++;
        end
      end
      m_pend = m_np | req;
      m_endp = meas_end;
    end
  end

  int         done_cnt = 0;
  logic [1:0] done_ch[$];
  initial forever begin
    @(negedge std_clk);
    if (done === 1'b1) begin
      done_cnt++;
      done_ch.push_back(result_ch);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("sel",          32'(sel),          32'(m_sel));
    check("meas_start",   32'(meas_start),   32'(m_busy && m_t == SETTLE));
    check("busy",         32'(busy),         32'(m_busy));
    check("done",         32'(done),         32'(m_done));
    check("meas_abort_n", 32'(meas_abort_n), 32'(!m_abort));
    check("result",       32'(result),       32'(m_res));
    check("result_ch",    32'(result_ch),    32'(m_rch));
    check("err",          32'(err),          32'(m_err));
    check("pending",      32'(pending),      32'(m_pend));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge std_clk);
      if (chk_on) compare_all();
    end
    #1;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < maxc) begin
      cyc(1);
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s: done not seen within %0d cycles", nm, maxc);
    end
  endtask

  task automatic count_until_start(output int n);
    n = 0;
    while (meas_start !== 1'b1 && n < 50) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic count_until_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      cyc(1);
      n++;
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, dc;
    int exp_rr[6];
    exp_rr = '{0, 1, 2, 3, 0, 1};

    // Reset state
    #2 std_reset = 1'b0;
    chk_on = 1'b1;
    cyc(3);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_abort_n", 32'(meas_abort_n), 32'd1);
    std_reset = 1'b1;
    cyc(2);

    // Round-robin from reset priority
    meter_lat = 3; meas_val = 10'd100;
    base = done_ch.size();
    req = 4'b1111; cyc(1); req = 4'b0000;
    repeat (4) begin wait_done(40, "rr_first"); cyc(1); end
    req = 4'b0011; cyc(1); req = 4'b0000;
    repeat (2) begin wait_done(40, "rr_second"); cyc(1); end
    check("rr_count", 32'(done_ch.size() - base), 32'd6);
    for (int i = 0; i < 6; i++)
      if (base + i < done_ch.size()) check("rr_order", 32'(done_ch[base + i]), 32'(exp_rr[i]));
    cyc(2);

    // Single request on channel 2
    meter_lat = 20; meas_val = 10'd37;
    req = 4'b0100; cyc(1); req = 4'b0000;
    check("single_pending", 32'(pending), 32'b0100);
    count_until_start(n);
    check("single_start_lat", 32'(n), 32'd5);
    check("single_sel", 32'(sel), 32'd2);
    wait_done(60, "single_done");
    check("single_result", 32'(result), 32'd37);
    check("single_ch", 32'(result_ch), 32'd2);
    check("single_err", 32'(err), 32'd0);
    cyc(2);

    // Timeout on channel 3
    meter_lat = 0;
    req = 4'b1000; cyc(1); req = 4'b0000;
    count_until_start(n);
    count_until_done(n);
    check("to_cycles", 32'(n), 32'd101);
    check("to_err", 32'(err), 32'd1);
    check("to_result", 32'(result), 32'd0);
    check("to_abort_n", 32'(meas_abort_n), 32'd0);
    check("to_busy_done", 32'(busy), 32'd0);
    cyc(1);
    check("to_busy_next", 32'(busy), 32'd0);
    check("to_abort_n_next", 32'(meas_abort_n), 32'd1);
    check("to_done_next", 32'(done), 32'd0);

    // Spurious end while idle
    dc = done_cnt;
    spur_end = 1'b1; cyc(1); spur_end = 1'b0;
    cyc(4);
    check("spur_done_cnt", 32'(done_cnt), 32'(dc));
    check("spur_busy", 32'(busy), 32'd0);

    // End edge on the final wait cycle beats the timeout
    meter_lat = 100; meas_val = 10'd555;
    req = 4'b0001; cyc(1); req = 4'b0000;
    count_until_start(n);
    count_until_done(n);
    check("coin_cycles", 32'(n), 32'd101);
    check("coin_err", 32'(err), 32'd0);
    check("coin_result", 32'(result), 32'd555);
    check("coin_ch", 32'(result_ch), 32'd0);
    cyc(1);

    // Request coinciding with its own grant keeps the channel pending
    meter_lat = 5; meas_val = 10'd9;
    base = done_ch.size();
    req = 4'b0010; cyc(1);
    cyc(1); req = 4'b0000;
    check("dbl_pending", 32'(pending), 32'b0010);
    check("dbl_busy", 32'(busy), 32'd1);
    check("dbl_sel", 32'(sel), 32'd1);
    wait_done(40, "dbl_first"); cyc(1);
    wait_done(40, "dbl_second"); cyc(1);
    check("dbl_count", 32'(done_ch.size() - base), 32'd2);
    if (done_ch.size() >= base + 2) begin
      check("dbl_ch_a", 32'(done_ch[base]), 32'd1);
      check("dbl_ch_b", 32'(done_ch[base + 1]), 32'd1);
    end
    check("dbl_pending_end", 32'(pending), 32'd0);
    cyc(2);

    // Reset in the middle of a wait
    meter_lat = 0;
    req = 4'b0001; cyc(1); req = 4'b0000;
    cyc(6);
    req = 4'b0100; cyc(1); req = 4'b0000;
    cyc(3);
    check("mid_in_wait", 32'(busy), 32'd1);
    dc = done_cnt;
    std_reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pending", 32'(pending), 32'd0);
    check("mid_rst_sel", 32'(sel), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_start", 32'(meas_start), 32'd0);
    cyc(2);
    std_reset = 1'b1;
    meter_lat = 7; meas_val = 10'd42;
    req = 4'b0001; cyc(1); req = 4'b0000;
    wait_done(40, "mid_recover");
    check("mid_done_cnt", 32'(done_cnt), 32'(dc + 1));
    check("mid_result", 32'(result), 32'd42);
    check("mid_ch", 32'(result_ch), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
